axis_gain_clipper: RTL
======================

Name: axis_gain_clipper

Overview:
Parametrised AXI-Stream gain and clipping stage for the Pmod I2S2 audio path, sitting between the I2S2 receive and transmit AXIS controllers. Each packet holds NUM_CH signed samples. The block buffers the packet, then scales it by a runtime Q1.(GAIN_WIDTH-1) gain with saturation. It applies one of several clip modes against a runtime threshold and replays the packet on the master interface. It also reports framing errors and a count of clipped samples.

Parameters:
DATA_WIDTH, 24, sample width, signed two's complement.
NUM_CH, 2, words (channels) per packet, >=1.
GAIN_WIDTH, 8, gain width, unsigned Q1.(GAIN_WIDTH-1); unity = 2^(GAIN_WIDTH-1).
CNT_WIDTH, 16, clip counter width.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
gain  in  GAIN_WIDTH  gain, quasi-static
thresh  in  DATA_WIDTH-1  clip magnitude, unsigned
mode  in  2  00 saturate-only, 01 symmetric hard clip, 10 asymmetric clip, 11 = 01
s_axis_data  in  DATA_WIDTH  input sample
s_axis_valid  in  1  input valid
s_axis_ready  out  1  input ready
s_axis_last  in  1  last word of packet
m_axis_data  out  DATA_WIDTH  output sample
m_axis_valid  out  1  output valid
m_axis_ready  in  1  downstream ready
m_axis_last  out  1  last word of packet
framing_err  out  1  one-cycle pulse on packet length mismatch
clip_cnt  out  CNT_WIDTH  clipped or saturated sample count, saturating

Behaviour:
- Reset values: s_axis_ready=0, m_axis_valid=0, m_axis_last=0, m_axis_data=0, framing_err=0, clip_cnt=0, state=RECV, index=0. s_axis_ready rises the first cycle after rst deasserts.
- Reset mid-operation: buffered packet discarded; no partial output.
- FSM states: RECV, CALC, SEND.
- RECV:
  - s_axis_ready=1.
  - Each handshake writes buf[idx] and increments idx.
  - The packet ends on s_axis_last or when idx==NUM_CH-1, whichever comes first.
  - s_axis_last with idx<NUM_CH-1: remaining words are zero-filled and framing_err pulses.
  - idx==NUM_CH-1 without s_axis_last: the word is accepted as the last one and framing_err pulses.
  - s_axis_ready drops the cycle after the ending handshake; the state then goes to CALC.
- CALC:
  - gain, thresh and mode are sampled once on entry and held for the whole packet.
  - One channel is processed per cycle, writing back into buf; this takes NUM_CH cycles, then the state goes to SEND.
- Datapath, per sample x:
  - p = x * gain, signed, DATA_WIDTH+GAIN_WIDTH+1 bits.
  - y = p >>> (GAIN_WIDTH-1), arithmetic shift, truncation toward minus infinity.
  - Saturate y to [-2^(DW-1), 2^(DW-1)-1].
  - Then clip: mode 00 none. Mode 01/11 limit to [-thresh, +thresh]. Mode 10 limit to [-(thresh>>1), +thresh].
  - thresh=0 in modes 01/10/11 gives output 0.
  - clip_cnt increments by 1 per sample altered by saturation or clipping, and holds at all-ones.
- SEND:
  - m_axis_valid=1, m_axis_data=buf[idx], m_axis_last=(idx==NUM_CH-1).
  - idx advances only on m_axis_valid & m_axis_ready; data and last stay stable while ready is low.
  - After the last handshake: m_axis_valid=0 and s_axis_ready=1 on the next cycle, state RECV.
- Latency: last input handshake at cycle T gives the first m_axis_valid at T+NUM_CH+1.
- No input is accepted in CALC or SEND.
- Gain or thresh changes during CALC or SEND take effect from the next packet.

Decomposition:
- Shared package audio_fx_pkg holds the mode encodings (MODE_SAT, MODE_HARD, MODE_ASYM) and the FSM state enum.
- Sub-module gain_clip_datapath: combinational multiply, shift, saturate and clip, with outputs y and clipped flag. Parametrised by DATA_WIDTH and GAIN_WIDTH.

Test Plan:
- Unity gain 0x80, mode 00, packet {0x123456, 0xFEDCBA} -> output {0x123456, 0xFEDCBA}, m_axis_last on word 2, valid at T+3, clip_cnt=0.
- gain=0xFF, mode 00, {0x600000, 0xA00000} -> {0x7FFFFF, 0x800000}, clip_cnt=2.
- Mode 01, thresh=0x100000, unity gain, {0x200000, 0xE80000} -> {0x100000, 0xF00000}. Input {0x0C0000, 0xFF0000} passes unchanged.
- Mode 10, thresh=0x100000, {0x0C0000, 0xE00000} -> {0x0C0000, 0xF80000}, clip_cnt +1.
- m_axis_ready held low 5 cycles in SEND -> data, last and valid stable, s_axis_ready=0. Early s_axis_last on word 0 -> framing_err 1-cycle pulse, channel 1 outputs 0.
- rst asserted mid-SEND -> next cycle m_axis_valid=0 and clip_cnt=0. s_axis_ready=1 the cycle after rst deasserts, and the next packet processes normally.

Source files
------------

// File: rtl/audio_fx_pkg.sv
// Shared definitions for the audio effect blocks: clip mode encodings and
// the packet-processing FSM state type.
package audio_fx_pkg;

  // Clip mode encodings (2'b11 behaves like MODE_HARD)
  localparam logic [1:0] MODE_SAT  = 2'b00;  // saturate only
  localparam logic [1:0] MODE_HARD = 2'b01;  // symmetric clip to +/-thresh
  localparam logic [1:0] MODE_ASYM = 2'b10;  // +thresh / -(thresh>>1)

  // Packet FSM: collect words, process one channel per cycle, replay
  typedef enum logic [1:0] {
    RECV = 2'b00,
    CALC = 2'b01,
    SEND = 2'b10
  } state_t;

endpackage

// File: rtl/gain_clip_datapath.sv
// Combinational gain/saturate/clip for one signed sample.
// Gain is unsigned Q1.(GAIN_WIDTH-1); the scaled value is floored, saturated
// to the sample range and then limited by the selected clip mode.
module gain_clip_datapath
  import audio_fx_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int GAIN_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic [GAIN_WIDTH-1:0] gain_i,
  input  logic [DATA_WIDTH-2:0] thresh_i,
  input  logic [1:0]            mode_i,
  output logic [DATA_WIDTH-1:0] y_o,
  output logic                  clipped_o
);

  localparam int DW = DATA_WIDTH;
  localparam int GW = GAIN_WIDTH;
  localparam int PW = DW + GW + 1;

  logic signed [PW-1:0] x_ext;
  logic signed [PW-1:0] g_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;
  logic                 ovf;
  logic [DW-1:0]        y_sat;
  logic signed [DW:0]   ys;
  logic signed [DW:0]   hi;
  logic signed [DW:0]   lo;
  logic                 clip_en;
  logic                 clip_hit;

  // Multiply and floor-shift; overflow when the bits above the sample sign differ
  always_comb begin
    x_ext   = {{(GW+1){x_i[DW-1]}}, x_i};
    g_ext   = {{(DW+1){1'b0}}, gain_i};
    prod    = x_ext * g_ext;
    shifted = prod >>> (GW-1);
    ovf     = ~((&shifted[PW-1:DW-1]) | ~(|shifted[PW-1:DW-1]));
    if (!ovf) begin
      y_sat = shifted[DW-1:0];
    end else if (shifted[PW-1]) begin
      y_sat = {1'b1, {(DW-1){1'b0}}};
    end else begin
      y_sat = {1'b0, {(DW-1){1'b1}}};
    end
  end

  // Clip window selection; one extra bit keeps -thresh and comparisons exact
  always_comb begin
    ys      = {y_sat[DW-1], y_sat};
    hi      = {2'b00, thresh_i};
    lo      = -hi;
    clip_en = 1'b1;
    case (mode_i)
      MODE_SAT:  clip_en = 1'b0;
      MODE_ASYM: lo = -$signed({3'b000, thresh_i[DW-2:1]});
      default:   lo = -hi;
    endcase
  end

  // Apply the clip window and flag any alteration of the sample
  always_comb begin
    y_o      = y_sat;
    clip_hit = 1'b0;
    if (clip_en && (ys > hi)) begin
      y_o      = hi[DW-1:0];
      clip_hit = 1'b1;
    end else if (clip_en && (ys < lo)) begin
      y_o      = lo[DW-1:0];
      clip_hit = 1'b1;
    end
    clipped_o = ovf | clip_hit;
  end

endmodule

// File: rtl/axis_gain_clipper.sv
// AXI-Stream gain and clipping stage: buffers one NUM_CH-word packet,
// scales/clips it in place one channel per cycle, then replays it.
module axis_gain_clipper
  import audio_fx_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_CH     = 2,
  parameter int GAIN_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [GAIN_WIDTH-1:0] gain,
  input  logic [DATA_WIDTH-2:0] thresh,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  input  logic                  s_axis_last,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic                  m_axis_last,
  output logic                  framing_err,
  output logic [CNT_WIDTH-1:0]  clip_cnt
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [GAIN_WIDTH-1:0] gain_q;
  logic [DATA_WIDTH-2:0] thresh_q;
  logic [1:0]            mode_q;
  logic [DATA_WIDTH-1:0] buf_q [NUM_CH];
  logic [DATA_WIDTH-1:0] buf_d [NUM_CH];

  logic                  in_hs;
  logic                  in_end;
  logic                  calc_we;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] dp_y;
  logic                  dp_clipped;

  assign rd_word = buf_q[idx_q];

  gain_clip_datapath #(
    .DATA_WIDTH(DATA_WIDTH),
    .GAIN_WIDTH(GAIN_WIDTH)
  ) u_dp (
    .x_i      (rd_word),
    .gain_i   (gain_q),
    .thresh_i (thresh_q),
    .mode_i   (mode_q),
    .y_o      (dp_y),
    .clipped_o(dp_clipped)
  );

  // Next-state logic: packet framing, channel sequencing and clip counting
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    in_hs   = 1'b0;
    in_end  = 1'b0;
    calc_we = 1'b0;
    case (state_q)
      RECV: begin
        in_hs  = ready_q & s_axis_valid;
        in_end = in_hs & (s_axis_last | (idx_q == LAST_IDX));
        if (in_end) begin
          idx_d   = '0;
          state_d = CALC;
          // Mismatch either way: early last, or full packet with no last
          err_d   = s_axis_last ^ (idx_q == LAST_IDX);
        end else if (in_hs) begin
          idx_d = idx_q + 1'b1;
        end
      end
      CALC: begin
        calc_we = 1'b1;
        if (dp_clipped && (cnt_q != '1)) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = SEND;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SEND: begin
        if (m_axis_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = RECV;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = RECV;
        idx_d   = '0;
      end
    endcase
    // Ready is registered so it follows the state with one cycle of delay
    ready_d = (state_d == RECV);
  end

  // Buffer next value: capture input, zero-fill on short packet, write back result
  always_comb begin
    buf_d = buf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_hs && (idx_q == IDX_W'(i))) begin
        buf_d[i] = s_axis_data;
      end else if (in_end && (IDX_W'(i) > idx_q)) begin
        buf_d[i] = '0;
      end else if (calc_we && (idx_q == IDX_W'(i))) begin
        buf_d[i] = dp_y;
      end
    end
  end

  // Control and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RECV;
      idx_q    <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      gain_q   <= '0;
      thresh_q <= '0;
      mode_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      // Settings latched as the packet closes so they hold for all its channels
      if (in_end) begin
        gain_q   <= gain;
        thresh_q <= thresh;
        mode_q   <= mode;
      end
    end
  end

  // Sample buffer; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign s_axis_ready = ready_q;
  assign m_axis_valid = (state_q == SEND);
  assign m_axis_data  = m_axis_valid ? rd_word : '0;
  assign m_axis_last  = m_axis_valid & (idx_q == LAST_IDX);
  assign framing_err  = err_q;
  assign clip_cnt     = cnt_q;

endmodule
